// File: rtl/stoplight_rounds.sv
// stoplight_rounds: multi-round stop-the-light puzzle for the bomb defusal game.
// A single lit LED bounces across an NUM_LIGHTS bar graph. The player must
// release the stop button while the light sits on the target index. Each
// round draws a random version that selects the target, and every round
// the light moves faster. The module defuses after ROUNDS correct stops.
//
// Ports:
//   clock_65mhz    in   system clock, all logic on posedge
//   reset          in   asynchronous active-high reset
//   enable         in   module active; low freezes state, counters, outputs
//   button_stop    in   debounced, synchronised stop button (1 = pressed)
//   rng_output     in   shared RNG value, valid the cycle after rng_enable
//   step_enable    in   single-cycle timebase strobe
//   strike         out  one-cycle pulse on a wrong stop
//   module_defused out  sticky high once ROUNDS correct stops are made
//   version        out  version of the current round
//   rng_enable     out  one-cycle RNG request
//   round          out  correct stops completed so far
//   bar            out  bar-graph drive, bar[NUM_LIGHTS-1-index] = lit light
//
// Configuration macro: STOPLIGHT_STRIKE_RESTART_EN
//   defined   : a wrong stop clears round and the penalty exit draws a new version
//   undefined : round is kept and the penalty exit resumes with the same target

module stoplight_rounds #(
  parameter int unsigned NUM_LIGHTS    = 10,
  parameter int unsigned ROUNDS        = 3,
  parameter int unsigned STEP_DIV      = 4,
  parameter int unsigned PENALTY_TICKS = 2,
  parameter int unsigned TARGET_A      = 5,
  parameter int unsigned TARGET_B      = 8,
  parameter int unsigned TARGET_C      = 3,
  parameter int unsigned TARGET_D      = 0
) (
  input  logic                  clock_65mhz,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  button_stop,
  input  logic [3:0]            rng_output,
  input  logic                  step_enable,
  output logic                  strike,
  output logic                  module_defused,
  output logic [1:0]            version,
  output logic                  rng_enable,
  output logic [2:0]            round,
  output logic [NUM_LIGHTS-1:0] bar
);

  localparam int unsigned IDX_W = $clog2(NUM_LIGHTS);
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LIGHTS - 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(NUM_LIGHTS / 2);
  localparam logic [CNT_W-1:0] STEP_DIV_C = CNT_W'(STEP_DIV);
  localparam logic [CNT_W-1:0] PEN_TICKS_C = CNT_W'(PENALTY_TICKS);
  localparam logic [2:0] ROUNDS_C = 3'(ROUNDS);

  typedef enum logic [2:0] {
    ST_DRAW,
    ST_SAMPLE,
    ST_MOVING,
    ST_HELD,
    ST_PENALTY,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             dir_right_q, dir_right_d;
  logic [CNT_W-1:0] divider_q, divider_d;
  logic [CNT_W-1:0] pen_q, pen_d;
  logic [IDX_W-1:0] target_q, target_d;
  logic [1:0]       version_d;
  logic [2:0]       round_d;
  logic             strike_d;
  logic             rng_enable_d;
  logic             defused_d;
  logic             btn_q;

  logic             press;
  logic [CNT_W-1:0] div_shifted;
  logic [CNT_W-1:0] div_lim;
  logic [IDX_W-1:0] next_index;
  logic [2:0]       round_inc;
  logic             unused_rng;

  // Only the low two RNG bits select a version.
  assign unused_rng = ^rng_output[3:2];

  function automatic logic [IDX_W-1:0] target_for(input logic [1:0] v);
    case (v)
      2'd0:    target_for = IDX_W'(TARGET_A);
      2'd1:    target_for = IDX_W'(TARGET_B);
      2'd2:    target_for = IDX_W'(TARGET_C);
      default: target_for = IDX_W'(TARGET_D);
    endcase
  endfunction

  // Move period shrinks by half each round, never below one tick.
  always_comb begin
    div_shifted = STEP_DIV_C >> round;
    div_lim     = (div_shifted > CNT_W'(1)) ? div_shifted - CNT_W'(1) : '0;
  end

  assign press      = button_stop & ~btn_q;
  assign next_index = dir_right_q ? index_q + IDX_W'(1) : index_q - IDX_W'(1);
  assign round_inc  = round + 3'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    dir_right_d  = dir_right_q;
    divider_d    = divider_q;
    pen_d        = pen_q;
    target_d     = target_q;
    version_d    = version;
    round_d      = round;
    defused_d    = module_defused;
    strike_d     = 1'b0;
    rng_enable_d = 1'b0;

    if (enable) begin
      case (state_q)
        ST_DRAW: begin
          rng_enable_d = 1'b1;
          state_d      = ST_SAMPLE;
        end

        // rng_enable is high during the first SAMPLE cycle; the RNG value is
        // valid one cycle later, so latch only once the request has dropped.
        ST_SAMPLE: begin
          if (!rng_enable) begin
            version_d = rng_output[1:0];
            target_d  = target_for(rng_output[1:0]);
            divider_d = '0;
            state_d   = ST_MOVING;
          end
        end

        ST_MOVING: begin
          if (press) begin
            state_d = ST_HELD;
          end else if (step_enable) begin
            if (divider_q == div_lim) begin
              divider_d = '0;
              index_d   = next_index;
              // Flip on arrival so each end light is shown for one period only.
              if (next_index == IDX_LAST) begin
                dir_right_d = 1'b0;
              end else if (next_index == '0) begin
                dir_right_d = 1'b1;
              end
            end else begin
              divider_d = divider_q + CNT_W'(1);
            end
          end
        end

        ST_HELD: begin
          if (!button_stop) begin
            if (index_q == target_q) begin
              round_d = round_inc;
              if (round_inc == ROUNDS_C) begin
                defused_d = 1'b1;
                state_d   = ST_DONE;
              end else begin
                state_d = ST_DRAW;
              end
            end else begin
              strike_d = 1'b1;
              pen_d    = '0;
              state_d  = ST_PENALTY;
`ifdef STOPLIGHT_STRIKE_RESTART_EN
              round_d  = '0;
`endif
            end
          end
        end

        ST_PENALTY: begin
          if (step_enable && (pen_q < PEN_TICKS_C)) begin
            pen_d = pen_q + CNT_W'(1);
          end
          if ((pen_q >= PEN_TICKS_C) && !button_stop) begin
            divider_d = '0;
`ifdef STOPLIGHT_STRIKE_RESTART_EN
            state_d   = ST_DRAW;
`else
            state_d   = ST_MOVING;
`endif
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_DRAW;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      state_q        <= ST_DRAW;
      index_q        <= IDX_MID;
      dir_right_q    <= 1'b1;
      divider_q      <= '0;
      pen_q          <= '0;
      target_q       <= '0;
      version        <= '0;
      round          <= '0;
      strike         <= 1'b0;
      rng_enable     <= 1'b0;
      module_defused <= 1'b0;
      btn_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      dir_right_q    <= dir_right_d;
      divider_q      <= divider_d;
      pen_q          <= pen_d;
      target_q       <= target_d;
      version        <= version_d;
      round          <= round_d;
      strike         <= strike_d;
      rng_enable     <= rng_enable_d;
      module_defused <= defused_d;
      // Tracks even while disabled so a press made then is not a later edge.
      btn_q          <= button_stop;
    end
  end

  // Bar decode from registered index and state.
  always_comb begin
    bar = '0;
    if (state_q == ST_PENALTY) begin
      bar = '1;
    end else begin
      bar[IDX_W'(IDX_LAST - index_q)] = 1'b1;
    end
  end

endmodule

// File: tb/tb_stoplight_rounds.sv
// Directed table-driven bench for stoplight_rounds with default parameters.
module tb_stoplight_rounds;

`ifdef STOPLIGHT_STRIKE_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  localparam logic [9:0] B0  = 10'b1000000000;
  localparam logic [9:0] B1  = 10'b0100000000;
  localparam logic [9:0] B3  = 10'b0001000000;
  localparam logic [9:0] B5  = 10'b0000010000;
  localparam logic [9:0] B6  = 10'b0000001000;
  localparam logic [9:0] B7  = 10'b0000000100;
  localparam logic [9:0] B8  = 10'b0000000010;
  localparam logic [9:0] B9  = 10'b0000000001;
  localparam logic [9:0] ALL = 10'h3FF;

  logic       clock_65mhz = 1'b0;
  logic       reset;
  logic       enable;
  logic       button_stop;
  logic [3:0] rng_output;
  logic       step_enable;
  logic       strike;
  logic       module_defused;
  logic [1:0] version;
  logic       rng_enable;
  logic [2:0] round;
  logic [9:0] bar;

  int n_vec = 0;
  int n_bad = 0;

  stoplight_rounds #(
    .NUM_LIGHTS(10), .ROUNDS(3), .STEP_DIV(4), .PENALTY_TICKS(2),
    .TARGET_A(5), .TARGET_B(8), .TARGET_C(3), .TARGET_D(0)
  ) dut (
    .clock_65mhz   (clock_65mhz),
    .reset         (reset),
    .enable        (enable),
    .button_stop   (button_stop),
    .rng_output    (rng_output),
    .step_enable   (step_enable),
    .strike        (strike),
    .module_defused(module_defused),
    .version       (version),
    .rng_enable    (rng_enable),
    .round         (round),
    .bar           (bar)
  );

  always #5 clock_65mhz = ~clock_65mhz;

  typedef struct packed {
    logic       en;
    logic       btn;
    logic       stp;
    logic [3:0] rng;
    logic       stk;
    logic       def;
    logic [1:0] ver;
    logic       rq;
    logic [2:0] rnd;
    logic [9:0] bar;
  } vec_t;

  vec_t tbl[45];

  function automatic vec_t mk(input logic en, input logic btn, input logic stp,
                              input logic [3:0] rng, input logic stk, input logic def,
                              input logic [1:0] ver, input logic rq, input logic [2:0] rnd,
                              input logic [9:0] b);
    vec_t v;
    v.en = en; v.btn = btn; v.stp = stp; v.rng = rng; v.stk = stk; v.def = def;
    v.ver = ver; v.rq = rq; v.rnd = rnd; v.bar = b;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic stk, input logic def,
                         input logic [1:0] ver, input logic rq, input logic [2:0] rnd,
                         input logic [9:0] b);
    chk({tag, ".strike"}, strike, stk);
    chk({tag, ".defused"}, module_defused, def);
    chk({tag, ".version"}, version, ver);
    chk({tag, ".rng_enable"}, rng_enable, rq);
    chk({tag, ".round"}, round, rnd);
    chk({tag, ".bar"}, bar, b);
  endtask

  // Apply inputs, clock once, then sample 1 time unit after the edge.
  task automatic cyc(input logic en, input logic btn, input logic stp);
    enable = en;
    button_stop = btn;
    step_enable = stp;
    @(posedge clock_65mhz);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] r1;
    r1 = RESTART ? 3'd0 : 3'd1;

    //            en btn stp rng  stk def ver rq rnd bar
    tbl[0]  = mk(1, 0, 0, 4'h1, 0, 0, 2'd0, 1, 3'd0, B5);
    tbl[1]  = mk(1, 0, 0, 4'h1, 0, 0, 2'd0, 0, 3'd0, B5);
    tbl[2]  = mk(1, 0, 0, 4'h1, 0, 0, 2'd1, 0, 3'd0, B5);
    tbl[3]  = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B5);
    tbl[4]  = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B5);
    tbl[5]  = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B5);
    tbl[6]  = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B6);
    tbl[7]  = mk(1, 0, 0, 4'h1, 0, 0, 2'd1, 0, 3'd0, B6);
    tbl[8]  = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B6);
    tbl[9]  = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B6);
    tbl[10] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B6);
    tbl[11] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B7);
    // disabled: ticks ignored
    tbl[12] = mk(0, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B7);
    tbl[13] = mk(0, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B7);
    tbl[14] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B7);
    tbl[15] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B7);
    tbl[16] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B7);
    tbl[17] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    // press while disabled is not an edge once enabled
    tbl[18] = mk(0, 1, 0, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[19] = mk(1, 1, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[20] = mk(1, 1, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[21] = mk(1, 1, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[22] = mk(1, 1, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B9);
    // end light held one period, then bounce back
    tbl[23] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B9);
    tbl[24] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B9);
    tbl[25] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B9);
    tbl[26] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[27] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[28] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[29] = mk(1, 0, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    // press coincides with a move tick: press wins
    tbl[30] = mk(1, 1, 1, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[31] = mk(1, 1, 0, 4'h1, 0, 0, 2'd1, 0, 3'd0, B8);
    tbl[32] = mk(1, 0, 0, 4'h1, 0, 0, 2'd1, 0, 3'd1, B8);
    // new draw, version 2 (target 3), period 2 ticks
    tbl[33] = mk(1, 0, 0, 4'h2, 0, 0, 2'd1, 1, 3'd1, B8);
    tbl[34] = mk(1, 0, 0, 4'h2, 0, 0, 2'd1, 0, 3'd1, B8);
    tbl[35] = mk(1, 0, 0, 4'h2, 0, 0, 2'd2, 0, 3'd1, B8);
    tbl[36] = mk(1, 0, 1, 4'h2, 0, 0, 2'd2, 0, 3'd1, B8);
    tbl[37] = mk(1, 0, 1, 4'h2, 0, 0, 2'd2, 0, 3'd1, B7);
    // wrong stop at 7, penalty held past its ticks
    tbl[38] = mk(1, 1, 0, 4'h2, 0, 0, 2'd2, 0, 3'd1, B7);
    tbl[39] = mk(1, 0, 0, 4'h2, 1, 0, 2'd2, 0, r1,   ALL);
    tbl[40] = mk(1, 0, 0, 4'h2, 0, 0, 2'd2, 0, r1,   ALL);
    tbl[41] = mk(1, 1, 1, 4'h2, 0, 0, 2'd2, 0, r1,   ALL);
    tbl[42] = mk(1, 1, 1, 4'h2, 0, 0, 2'd2, 0, r1,   ALL);
    tbl[43] = mk(1, 1, 0, 4'h2, 0, 0, 2'd2, 0, r1,   ALL);
    tbl[44] = mk(1, 0, 0, 4'h2, 0, 0, 2'd2, 0, r1,   B7);

    reset = 1'b1;
    enable = 1'b0;
    button_stop = 1'b0;
    step_enable = 1'b0;
    rng_output = 4'h1;
    repeat (3) @(posedge clock_65mhz);
    #1;
    reset = 1'b0;
    chk_all("reset", 0, 0, 2'd0, 0, 3'd0, B5);

    for (int i = 0; i < 45; i++) begin
      rng_output = tbl[i].rng;
      cyc(tbl[i].en, tbl[i].btn, tbl[i].stp);
      chk_all($sformatf("v%0d", i + 1), tbl[i].stk, tbl[i].def, tbl[i].ver,
              tbl[i].rq, tbl[i].rnd, tbl[i].bar);
    end

`ifndef STOPLIGHT_STRIKE_RESTART_EN
    // Resume at 7 going left, period 2: four moves reach target 3.
    steps(8);
    chk("resume.bar", bar, B3);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("stop2.round", round, 3'd2);
    chk("stop2.strike", strike, 0);
    rng_output = 4'h0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("draw3.rng_enable", rng_enable, 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("draw3.version", version, 2'd0);
    // Round 2: one tick per move, bounce at index 0.
    steps(3);
    chk("r2.at0", bar, B0);
    steps(1);
    chk("r2.at1", bar, B1);
    steps(4);
    chk("r2.at5", bar, B5);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("done", 0, 1, 2'd0, 0, 3'd3, B5);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, (i % 2) == 0, 1'b1);
      chk($sformatf("done_press%0d.strike", i), strike, 0);
      chk($sformatf("done_press%0d.defused", i), module_defused, 1);
    end
    chk("done_hold.round", round, 3'd3);
    chk("done_hold.bar", bar, B5);
`else
    // Restart build: penalty exit draws again with round cleared.
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart.rng_enable", rng_enable, 1);
    chk("restart.round", round, 3'd0);
    rng_output = 4'h1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart.version", version, 2'd1);
    chk("restart.rng_low", rng_enable, 0);
    chk("restart.bar", bar, B7);
`endif

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 2'd0, 0, 3'd0, B5);
    @(posedge clock_65mhz);
    #1;
    reset = 1'b0;
    rng_output = 4'h3;
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("post_reset", 0, 0, 2'd0, 1, 3'd0, B5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
